// File: rtl/light_cycle_ctrl.sv
// rtl/light_cycle_ctrl.sv - one-second sequencer, duration registers and pedestrian shortening
module light_cycle_ctrl #(
  parameter int CLK_DIV = 50000000,
  parameter int RED_DEF = 30,
  parameter int YEL_DEF = 5,
  parameter int GRE_DEF = 25,
  parameter int MIN_DUR = 1,
  parameter int MAX_DUR = 63,
  parameter int PED_REM = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       ped_req,
  output logic [7:0] count,
  output logic [5:0] red,
  output logic [5:0] yel,
  output logic [5:0] gre,
  output logic [1:0] cfg_mode,
  output logic       tick,
  output logic       ped_pend,
  output logic       ped_ack
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_RED = 2'd1, SET_YEL = 2'd2, SET_GRE = 2'd3} state_t;

  localparam int             PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [5:0]     MAX6     = 6'(MAX_DUR);
  localparam logic [5:0]     MIN6     = 6'(MIN_DUR);
  localparam logic [7:0]     PED8     = 8'(PED_REM);

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_count;
  logic [5:0]    r_red;
  logic [5:0]    r_yel;
  logic [5:0]    r_gre;
  logic          r_tick;
  logic          r_pend;
  logic          r_ack;

  logic [7:0]    w_gstart;
  logic [7:0]    w_total;
  logic [7:0]    w_left;
  logic          w_wrap;
  logic          w_up;
  logic          w_dn;

  // Durations are at most 63 each, so the 8-bit sum cannot overflow.
  assign w_gstart = {2'b00, r_red} + {2'b00, r_yel};
  assign w_total  = w_gstart + {2'b00, r_gre};
  assign w_left   = w_total - r_count;
  assign w_wrap   = (r_pre == PRE_LAST);
  assign w_up     = key_inc & ~key_dec;
  assign w_dn     = key_dec & ~key_inc;

  function automatic logic [5:0] f_adj(input logic [5:0] v, input logic up, input logic dn);
    if (up && v < MAX6) return v + 6'd1;
    if (dn && v > MIN6) return v - 6'd1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_pre   <= '0;
      r_count <= 8'd0;
      r_red   <= 6'(RED_DEF);
      r_yel   <= 6'(YEL_DEF);
      r_gre   <= 6'(GRE_DEF);
      r_tick  <= 1'b0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      // Any SET state, and any mode change, parks the sequencer at the cycle start.
      if (r_state != RUN || key_mode) begin
        r_pre   <= '0;
        r_count <= 8'd0;
        r_pend  <= 1'b0;
      end
      case (r_state)
        RUN: begin
          if (key_mode) begin
            r_state <= SET_RED;
          end else begin
            if (w_wrap) begin
              r_pre  <= '0;
              r_tick <= 1'b1;
              if (r_count >= w_total) begin
                r_count <= 8'd1;
                r_pend  <= 1'b0;
              end else if (r_pend && r_count > w_gstart && w_left > PED8) begin
                r_count <= w_total - PED8;
                r_pend  <= 1'b0;
                r_ack   <= 1'b1;
              end else begin
                r_count <= r_count + 8'd1;
              end
            end else begin
              r_pre <= r_pre + PW'(1);
            end
            // A fresh request outranks the clear done by an applying tick.
            if (ped_req) r_pend <= 1'b1;
          end
        end
        SET_RED: begin
          if (key_mode) r_state <= SET_YEL;
          else          r_red   <= f_adj(r_red, w_up, w_dn);
        end
        SET_YEL: begin
          if (key_mode) r_state <= SET_GRE;
          else          r_yel   <= f_adj(r_yel, w_up, w_dn);
        end
        SET_GRE: begin
          if (key_mode) r_state <= RUN;
          else          r_gre   <= f_adj(r_gre, w_up, w_dn);
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign count    = r_count;
  assign red      = r_red;
  assign yel      = r_yel;
  assign gre      = r_gre;
  assign cfg_mode = r_state;
  assign tick     = r_tick;
  assign ped_pend = r_pend;
  assign ped_ack  = r_ack;

endmodule

// File: tb/tb_light_cycle_ctrl.sv
// tb/tb_light_cycle_ctrl.sv - directed self-checking bench for light_cycle_ctrl
module tb_light_cycle_ctrl;

  logic       clk;
  logic       rst;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic       ped_req;
  logic [7:0] count;
  logic [5:0] red;
  logic [5:0] yel;
  logic [5:0] gre;
  logic [1:0] cfg_mode;
  logic       tick;
  logic       ped_pend;
  logic       ped_ack;

  int n_checks = 0;
  int n_fail   = 0;

  light_cycle_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .ped_req(ped_req), .count(count), .red(red), .yel(yel), .gre(gre),
    .cfg_mode(cfg_mode), .tick(tick), .ped_pend(ped_pend), .ped_ack(ped_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_count(input string tag, input logic [7:0] target);
    int n = 0;
    while (count !== target && n < 2000) begin
      step();
      n++;
    end
    chk(tag, count, target);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    step();
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, tick, 1);
  endtask

  task automatic pulse_inc(input int times);
    for (int i = 0; i < times; i++) begin
      key_inc = 1'b1;
      step();
      key_inc = 1'b0;
    end
  endtask

  task automatic pulse_dec(input int times);
    for (int i = 0; i < times; i++) begin
      key_dec = 1'b1;
      step();
      key_dec = 1'b0;
    end
  endtask

  task automatic pulse_mode();
    key_mode = 1'b1;
    step();
    key_mode = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_red"}, red, 30);
    chk({tag, "_yel"}, yel, 5);
    chk({tag, "_gre"}, gre, 25);
    chk({tag, "_mode"}, cfg_mode, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_pend"}, ped_pend, 0);
    chk({tag, "_ack"}, ped_ack, 0);
  endtask

  initial begin
    int bad;
    int prev;
    int n;
    rst = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0; ped_req = 1'b0;
    step();
    step();
    chk_reset("rst0");

    // Tick on every 4th cycle after release; count follows it.
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick_k%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("count_k%0d", k), count, k / 4);
    end

    // Count advances by exactly one per tick up to 60.
    bad = 0; prev = count; n = 0;
    while (count != 8'd60 && n < 400) begin
      step();
      n++;
      if (tick) begin
        if (count != prev + 1) bad++;
      end else if (count != prev) bad++;
      prev = count;
    end
    chk("seq_to_60", bad, 0);
    chk("reach_60", count, 60);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("hold60_%0d", i), count, 60);
    end
    step();
    chk("wrap_count", count, 1);
    chk("wrap_tick", tick, 1);

    // Request in green: next tick jumps to total - 5.
    wait_count("reach_40", 8'd40);
    pulse_ped();
    chk("ped40_pend", ped_pend, 1);
    wait_tick("ped40_tick");
    chk("ped40_count", count, 55);
    chk("ped40_ack", ped_ack, 1);
    chk("ped40_pend_clr", ped_pend, 0);
    step();
    chk("ped40_ack_1cyc", ped_ack, 0);

    // Request during red waits until count is strictly past red+yel (35).
    wait_count("reach_10", 8'd10);
    pulse_ped();
    chk("ped10_pend", ped_pend, 1);
    wait_count("reach_35", 8'd35);
    chk("ped10_pend35", ped_pend, 1);
    wait_tick("ped10_tick36");
    chk("ped10_count36", count, 36);
    chk("ped10_noack36", ped_ack, 0);
    wait_tick("ped10_tick_jump");
    chk("ped10_count55", count, 55);
    chk("ped10_ack", ped_ack, 1);

    // Too little green left: no jump, pending cleared at the wrap.
    wait_count("reach_57", 8'd57);
    pulse_ped();
    chk("ped57_pend", ped_pend, 1);
    wait_tick("ped57_tick");
    chk("ped57_count58", count, 58);
    chk("ped57_noack", ped_ack, 0);
    wait_count("ped57_reach60", 8'd60);
    chk("ped57_pend60", ped_pend, 1);
    wait_tick("ped57_wrap");
    chk("ped57_wrap_count", count, 1);
    chk("ped57_wrap_pend", ped_pend, 0);

    // Reset mid-run with a pending request.
    wait_count("reach_47", 8'd47);
    pulse_ped();
    chk("rst47_pend", ped_pend, 1);
    rst = 1'b0;
    step();
    chk_reset("rst47");
    rst = 1'b1;
    step();

    // Configuration walk.
    pulse_mode();
    chk("set_red_mode", cfg_mode, 1);
    chk("set_red_count", count, 0);
    pulse_inc(1);
    chk("red_inc1", red, 31);
    pulse_inc(2);
    chk("red_inc3", red, 33);
    step(); step(); step(); step(); step();
    chk("set_count_held", count, 0);
    chk("set_tick_low", tick, 0);
    pulse_mode();
    chk("set_yel_mode", cfg_mode, 2);
    pulse_dec(10);
    chk("yel_sat_min", yel, 1);
    pulse_inc(1);
    chk("yel_inc", yel, 2);
    key_inc = 1'b1; key_dec = 1'b1;
    step();
    key_inc = 1'b0; key_dec = 1'b0;
    chk("yel_incdec", yel, 2);
    pulse_mode();
    chk("set_gre_mode", cfg_mode, 3);
    pulse_inc(50);
    chk("gre_sat_max", gre, 63);
    pulse_dec(1);
    chk("gre_dec", gre, 62);
    key_mode = 1'b1; key_inc = 1'b1;
    step();
    key_mode = 1'b0; key_inc = 1'b0;
    chk("mode_prio_mode", cfg_mode, 0);
    chk("mode_prio_gre", gre, 62);
    chk("run_count0", count, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("run_first_tick_k%0d", k), tick, (k == 4) ? 1 : 0);
    end
    chk("run_first_count", count, 1);
    pulse_inc(1);
    chk("run_keys_ignored", red, 33);

    // Reset from SET_RED with red=40; ped_req ignored in SET.
    pulse_mode();
    chk("set2_mode", cfg_mode, 1);
    pulse_inc(7);
    chk("red_40", red, 40);
    pulse_ped();
    chk("set_ped_ignored", ped_pend, 0);
    rst = 1'b0;
    step();
    chk_reset("rst_set");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
